// File: rtl/tff_bank_arbiter.sv
// Round-robin arbiter/sequencer sharing one WIDTH-bit toggle flip-flop bank among NREQ requesters.
// Optional TFF_BANK_PARITY_EN adds a registered parity output of the bank.
module tff_bank_arbiter #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 4
) (
  input  logic                   clk,
  input  logic                   clr_n,
  input  logic                   sclr,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ*WIDTH-1:0]  mask,
  input  logic [NREQ*CNT_W-1:0]  count,
  output logic [NREQ-1:0]        grant,
  output logic [NREQ-1:0]        done,
  output logic                   busy,
`ifdef TFF_BANK_PARITY_EN
  output logic                   parity,
`endif
  output logic [WIDTH-1:0]       q
);

  localparam int unsigned IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    IDLE,
    TOGGLE,
    DONE
  } state_t;

  state_t             state_q;
  logic [NREQ-1:0]    grant_q;
  logic [NREQ-1:0]    done_q;
  logic               busy_q;
  logic [WIDTH-1:0]   bank_q;
  logic [WIDTH-1:0]   bank_d;
  logic [IDX_W-1:0]   ptr_q;
  logic [IDX_W-1:0]   winner_q;
  logic [CNT_W-1:0]   remaining_q;
  logic [WIDTH-1:0]   mask_r_q;
`ifdef TFF_BANK_PARITY_EN
  logic               parity_q;
`endif

  logic [IDX_W-1:0]   cand;
  logic [IDX_W-1:0]   arb_idx;
  logic               arb_hit;
  logic [NREQ-1:0]    arb_oh;
  logic [WIDTH-1:0]   arb_mask;
  logic [CNT_W-1:0]   arb_count;
  logic [IDX_W-1:0]   ptr_inc;
  logic               abort;

  // First pending requester at or after the rr pointer, with wrap-around.
  always_comb begin
    arb_hit = 1'b0;
    arb_idx = ptr_q;
    cand    = ptr_q;
    for (int unsigned k = 0; k < NREQ; k++) begin
      cand = IDX_W'((32'(ptr_q) + k) % NREQ);
      if (!arb_hit && req[cand]) begin
        arb_hit = 1'b1;
        arb_idx = cand;
      end
    end
    arb_oh          = '0;
    arb_oh[arb_idx] = 1'b1;
    arb_mask        = mask[arb_idx*WIDTH +: WIDTH];
    arb_count       = count[arb_idx*CNT_W +: CNT_W];
  end

  always_comb begin
    ptr_inc = (winner_q == IDX_W'(NREQ - 1)) ? '0 : winner_q + 1'b1;
    abort   = (state_q == TOGGLE) && !req[winner_q];
    bank_d  = bank_q;
    if ((state_q == TOGGLE) && req[winner_q]) begin
      bank_d = bank_q ^ mask_r_q;
    end
    if (sclr) begin
      bank_d = '0;
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      done_q      <= '0;
      busy_q      <= 1'b0;
      bank_q      <= '0;
      ptr_q       <= '0;
      winner_q    <= '0;
      remaining_q <= '0;
      mask_r_q    <= '0;
`ifdef TFF_BANK_PARITY_EN
      parity_q    <= 1'b0;
`endif
    end else begin
      bank_q <= bank_d;
`ifdef TFF_BANK_PARITY_EN
      parity_q <= ^bank_d;
`endif
      done_q <= '0;
      case (state_q)
        IDLE: begin
          if (arb_hit) begin
            winner_q    <= arb_idx;
            grant_q     <= arb_oh;
            mask_r_q    <= arb_mask;
            remaining_q <= arb_count;
            busy_q      <= 1'b1;
            // A zero-length burst shows its grant and done together for one cycle.
            if (arb_count != '0) begin
              state_q <= TOGGLE;
            end else begin
              state_q <= DONE;
              done_q  <= arb_oh;
            end
          end
        end
        TOGGLE: begin
          if (abort) begin
            grant_q <= '0;
            ptr_q   <= ptr_inc;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            remaining_q <= remaining_q - 1'b1;
            if (remaining_q == CNT_W'(1)) begin
              done_q  <= grant_q;
              grant_q <= '0;
              state_q <= DONE;
            end
          end
        end
        DONE: begin
          grant_q <= '0;
          ptr_q   <= ptr_inc;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          grant_q <= '0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign grant = grant_q;
  assign done  = done_q;
  assign busy  = busy_q;
  assign q     = bank_q;
`ifdef TFF_BANK_PARITY_EN
  assign parity = parity_q;
`endif

endmodule

// File: tb/tb_tff_bank_arbiter.sv
// Directed self-checking bench for tff_bank_arbiter (NREQ=4, WIDTH=8, CNT_W=4).
module tb_tff_bank_arbiter;

  logic        clk;
  logic        clr_n;
  logic        sclr;
  logic [3:0]  req;
  logic [31:0] mask;
  logic [15:0] count;
  logic [3:0]  grant;
  logic [3:0]  done;
  logic        busy;
  logic [7:0]  q;
`ifdef TFF_BANK_PARITY_EN
  logic        parity;
`endif

  int n_cmp;
  int n_err;

  tff_bank_arbiter #(
    .NREQ  (4),
    .WIDTH (8),
    .CNT_W (4)
  ) dut (
    .clk   (clk),
    .clr_n (clr_n),
    .sclr  (sclr),
    .req   (req),
    .mask  (mask),
    .count (count),
    .grant (grant),
    .done  (done),
    .busy  (busy),
`ifdef TFF_BANK_PARITY_EN
    .parity(parity),
`endif
    .q     (q)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic check_q(input string tag, input logic [7:0] exp);
    check(tag, {24'h0, q}, {24'h0, exp});
`ifdef TFF_BANK_PARITY_EN
    check({tag, "_par"}, {31'h0, parity}, {31'h0, ^exp});
`endif
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_burst(input int i, input logic [7:0] m, input logic [3:0] c);
    mask[i*8 +: 8]  = m;
    count[i*4 +: 4] = c;
  endtask

  logic [3:0] rr_g [4];
  logic [7:0] rr_q [4];

  initial begin
    n_cmp = 0;
    n_err = 0;
    clr_n = 1'b0;
    sclr  = 1'b0;
    req   = '0;
    mask  = '0;
    count = '0;
    #7 clr_n = 1'b1;

    // reset / idle
    for (int i = 0; i < 10; i++) begin
      step();
      check_q("idle_q", 8'h00);
      check("idle_grant", {28'h0, grant}, 32'h0);
      check("idle_busy", {31'h0, busy}, 32'h0);
      check("idle_done", {28'h0, done}, 32'h0);
    end

    // single burst: mask 0F, count 3
    set_burst(0, 8'h0F, 4'd3);
    req = 4'b0001;
    step();
    check("sb_grant", {28'h0, grant}, 32'h1);
    check("sb_busy", {31'h0, busy}, 32'h1);
    check_q("sb_q0", 8'h00);
    step(); check_q("sb_q1", 8'h0F); check("sb_done1", {28'h0, done}, 32'h0);
    step(); check_q("sb_q2", 8'h00);
    step(); check_q("sb_q3", 8'h0F);
    check("sb_done", {28'h0, done}, 32'h1);
    check("sb_grant_clr", {28'h0, grant}, 32'h0);
    check("sb_busy_done", {31'h0, busy}, 32'h1);
    req = 4'b0000;
    step();
    check("sb_done_end", {28'h0, done}, 32'h0);
    check("sb_busy_end", {31'h0, busy}, 32'h0);
    check_q("sb_q_end", 8'h0F);

    // restart from pointer 0 for the round-robin pass
    clr_n = 1'b0;
    #2 clr_n = 1'b1;
    check_q("rst2_q", 8'h00);

    // round-robin, req=1011, all counts 1
    set_burst(0, 8'h01, 4'd1);
    set_burst(1, 8'h02, 4'd1);
    set_burst(2, 8'h04, 4'd1);
    set_burst(3, 8'h08, 4'd1);
    rr_g[0] = 4'b0001; rr_q[0] = 8'h01;
    rr_g[1] = 4'b0010; rr_q[1] = 8'h03;
    rr_g[2] = 4'b1000; rr_q[2] = 8'h0B;
    rr_g[3] = 4'b0001; rr_q[3] = 8'h0A;
    req = 4'b1011;
    for (int i = 0; i < 4; i++) begin
      step();
      check("rr_grant", {28'h0, grant}, {28'h0, rr_g[i]});
      step();
      check_q("rr_q", rr_q[i]);
      check("rr_done", {28'h0, done}, {28'h0, rr_g[i]});
      check("rr_grant_clr", {28'h0, grant}, 32'h0);
      step();
      check("rr_done_clr", {28'h0, done}, 32'h0);
    end
    req = 4'b0000;
    step();
    check("rr_idle_busy", {31'h0, busy}, 32'h0);

    // count=0 on requester 2 (pointer now 1)
    set_burst(2, 8'h44, 4'd0);
    req = 4'b0100;
    step();
    check("c0_grant", {28'h0, grant}, 32'h4);
    check("c0_done", {28'h0, done}, 32'h4);
    check_q("c0_q", 8'h0A);
    step();
    check("c0_done_clr", {28'h0, done}, 32'h0);
    check("c0_grant_clr", {28'h0, grant}, 32'h0);
    check_q("c0_q2", 8'h0A);
    req = 4'b0000;

    // abort requester 1 after two toggles (pointer now 3)
    set_burst(1, 8'h11, 4'd5);
    req = 4'b0010;
    step(); check("ab_grant", {28'h0, grant}, 32'h2);
    step(); check_q("ab_q1", 8'h1B);
    step(); check_q("ab_q2", 8'h0A);
    set_burst(3, 8'h80, 4'd1);
    req = 4'b1100;
    step();
    check("ab_grant_clr", {28'h0, grant}, 32'h0);
    check("ab_no_done", {28'h0, done}, 32'h0);
    check("ab_busy", {31'h0, busy}, 32'h0);
    check_q("ab_q_hold", 8'h0A);
    step();
    check("ab_next_grant", {28'h0, grant}, 32'h4);
    check("ab_next_done", {28'h0, done}, 32'h4);
    req = 4'b1000;
    step();
    check("ab_gap_grant", {28'h0, grant}, 32'h0);
    step();
    check("ab_g3", {28'h0, grant}, 32'h8);
    step();
    check_q("ab_q3", 8'h8A);
    check("ab_done3", {28'h0, done}, 32'h8);
    req = 4'b0000;
    step();

    // sclr while idle, then sclr colliding with toggle 2 (pointer now 0)
    sclr = 1'b1;
    step();
    sclr = 1'b0;
    check_q("sc_idle_q", 8'h00);
    set_burst(0, 8'hFF, 4'd4);
    req = 4'b0001;
    step(); check("sc_grant", {28'h0, grant}, 32'h1);
    step(); check_q("sc_t1", 8'hFF);
    sclr = 1'b1;
    step(); check_q("sc_t2", 8'h00);
    check("sc_grant_held", {28'h0, grant}, 32'h1);
    sclr = 1'b0;
    step(); check_q("sc_t3", 8'hFF);
    step(); check_q("sc_t4", 8'h00);
    check("sc_done", {28'h0, done}, 32'h1);
    req = 4'b0000;
    step();
    check("sc_done_clr", {28'h0, done}, 32'h0);

    // async reset mid-burst (pointer now 1)
    set_burst(1, 8'h3C, 4'd6);
    req = 4'b0010;
    step(); check("ar_grant", {28'h0, grant}, 32'h2);
    step(); check_q("ar_q1", 8'h3C);
    step(); check_q("ar_q2", 8'h00);
    step(); check_q("ar_q3", 8'h3C);
    #3 clr_n = 1'b0;
    #1;
    check_q("ar_q_rst", 8'h00);
    check("ar_grant_rst", {28'h0, grant}, 32'h0);
    check("ar_done_rst", {28'h0, done}, 32'h0);
    check("ar_busy_rst", {31'h0, busy}, 32'h0);
    req = 4'b0011;
    step();
    check("ar_hold_grant", {28'h0, grant}, 32'h0);
    check("ar_hold_done", {28'h0, done}, 32'h0);
    #2 clr_n = 1'b1;
    step();
    check("ar_restart_grant", {28'h0, grant}, 32'h1);
    check("ar_restart_busy", {31'h0, busy}, 32'h1);
    check("ar_restart_done", {28'h0, done}, 32'h0);
    req = 4'b0000;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/tff_bank_arbiter.md
Name: tff_bank_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one WIDTH-bit bank of toggle flip-flops among NREQ requesters.
- Each requester asks for a burst: a toggle mask plus a toggle count.
- The granted burst XORs its latched mask into the bank once per cycle for count cycles, then signals completion.
- Sits between software-style command sources and the shared TFF-bank datapath; it is the sole writer of that bank.

Parameters:
NREQ, 4, number of requesters (2..8)
WIDTH, 8, bits in the shared TFF bank
CNT_W, 4, width of each requester's toggle-count field

Ports:
clk  input  1  system clock, rising-edge
clr_n  input  1  asynchronous active-low reset
sclr  input  1  synchronous clear of the TFF bank (q <= 0), active-high
req  input  NREQ  per-requester request; must stay high, with mask/count stable, until done or abort
mask  input  NREQ*WIDTH  packed toggle masks, requester i at [i*WIDTH +: WIDTH]
count  input  NREQ*CNT_W  packed toggle counts, requester i at [i*CNT_W +: CNT_W]
grant  output  NREQ  one-hot grant, registered
done  output  NREQ  one-cycle completion pulse to the granted requester
busy  output  1  high in any state other than IDLE
q  output  WIDTH  shared TFF bank state

Behaviour:
- Reset (clr_n low, async): state=IDLE, q=0, grant=0, done=0, busy=0, rr pointer=0, remaining=0, mask_r=0.
- States: IDLE, TOGGLE, DONE.
- IDLE, any req high:
  - Winner = first requester with req high, searching from the rr pointer upward with wrap-around.
  - At the next edge: grant[winner]=1, mask_r=mask[winner], remaining=count[winner].
  - Go to TOGGLE if count!=0, else DONE.
- TOGGLE, each cycle:
  - q <= q ^ mask_r; remaining <= remaining-1.
  - When remaining==1 at the edge, take the final toggle and go to DONE.
- DONE: done[winner]=1 for exactly one cycle; grant cleared on the same edge; rr pointer = winner+1 (mod NREQ); go to IDLE.
- Latency, count=N≥1, req seen in IDLE at edge 0:
  - grant visible after edge 1.
  - Toggles at edges 2..N+1.
  - done high for the cycle after edge N+1.
  - IDLE after edge N+2; the next grant is possible at edge N+3.
- count=0: grant for one cycle, no toggle, done pulse, pointer advances.
- Abort: req[winner] low while in TOGGLE -> on the next edge, no toggle, grant=0, no done, pointer advances, go to IDLE. Toggles already applied persist.
- mask/count changes after grant are ignored (latched).
- sclr: q <= 0, with priority over a same-cycle toggle. It does not disturb the FSM, remaining, or grant; the burst continues from q=0.
- Fairness: a requester re-asserting req immediately after its done loses to any other pending requester.
- grant is always one-hot or zero; done is never asserted with a different grant bit.
- Mid-burst clr_n: everything returns to reset values immediately; no done is issued.

Optional Feature:
- Macro: TFF_BANK_PARITY_EN.
- Defined: adds output port parity (1 bit) = registered XOR-reduce of q. It updates on the same edge as q, is 0 on reset, and is 0 after sclr.
- Undefined: the port and its logic are absent; everything else is identical.

Test Plan:
- Reset/idle: clr_n=0 for 7ns then 1, no req -> q=8'h00, grant=0, busy=0 for 10 cycles.
- Single burst: req[0]=1, mask[0]=8'h0F, count[0]=3 -> q goes 00->0F->00->0F; done[0] pulse one cycle after the third toggle; busy low after the DONE cycle.
- Round-robin: req=4'b1011 held, all counts=1, masks=8'h01/8'h02/_/8'h08 -> grant order 0,1,3,0; q toggles correspondingly; each done pulses once per grant.
- count=0 and abort: req[2] with count=0 -> done[2] pulse and q unchanged. Then req[1] with count=5, drop req[1] after 2 toggles -> no done[1], q shows exactly 2 toggles, next grant goes to req[2]/[3] when pending.
- sclr collision: during burst mask=8'hFF, count=4, assert sclr on toggle 2 -> q=00 that cycle, remaining toggles continue (q=FF, then 00); done still issued.
- Async reset mid-burst: clr_n low during TOGGLE -> q, grant, done, busy = 0 immediately; after release, arbitration restarts at pointer 0.
